// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcode encodings, default datapath widths and
// the operand-forwarding source selector.
package cpu_pkg;

    localparam int XLEN_DEF = 32;
    localparam int RA_W_DEF = 5;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    typedef enum logic [1:0] {
        FWD_NONE  = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle between decode, the ID/EX stage, the downstream forwarding sources
// and the ALU. master = surrounding pipeline, slave = the ID/EX stage.
interface id_ex_stage_if #(
    parameter int XLEN = cpu_pkg::XLEN_DEF,
    parameter int RA_W = cpu_pkg::RA_W_DEF
);

    logic            flush;
    logic            id_valid;
    logic            id_ready;
    logic [3:0]      id_alu_control;
    logic [RA_W-1:0] id_rs1_addr;
    logic [RA_W-1:0] id_rs2_addr;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic            id_use_imm;
    logic [RA_W-1:0] id_rd_addr;
    logic            id_reg_write;
    logic            id_mem_read;

    logic [RA_W-1:0] exmem_rd;
    logic [RA_W-1:0] memwb_rd;
    logic            exmem_reg_write;
    logic            memwb_reg_write;
    logic [XLEN-1:0] exmem_result;
    logic [XLEN-1:0] memwb_result;

    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_control;
    logic [XLEN-1:0] ex_store_data;
    logic [RA_W-1:0] ex_rd_addr;
    logic            ex_reg_write;
    logic            ex_mem_read;

    modport master (
        output flush, id_valid, id_alu_control, id_rs1_addr, id_rs2_addr,
               id_rs1_data, id_rs2_data, id_imm, id_use_imm, id_rd_addr,
               id_reg_write, id_mem_read,
               exmem_rd, memwb_rd, exmem_reg_write, memwb_reg_write,
               exmem_result, memwb_result, ex_ready,
        input  id_ready, ex_valid, alu_a, alu_b, alu_control, ex_store_data,
               ex_rd_addr, ex_reg_write, ex_mem_read
    );

    modport slave (
        input  flush, id_valid, id_alu_control, id_rs1_addr, id_rs2_addr,
               id_rs1_data, id_rs2_data, id_imm, id_use_imm, id_rd_addr,
               id_reg_write, id_mem_read,
               exmem_rd, memwb_rd, exmem_reg_write, memwb_reg_write,
               exmem_result, memwb_result, ex_ready,
        output id_ready, ex_valid, alu_a, alu_b, alu_control, ex_store_data,
               ex_rd_addr, ex_reg_write, ex_mem_read
    );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding for one source register: EX/MEM beats MEM/WB beats the
// stored register-file value; x0 never matches.
module fwd_mux
    import cpu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int RA_W = RA_W_DEF
) (
    input  logic [RA_W-1:0] rs_addr,
    input  logic [XLEN-1:0] rs_data,
    input  logic [RA_W-1:0] exmem_rd,
    input  logic            exmem_reg_write,
    input  logic [XLEN-1:0] exmem_result,
    input  logic [RA_W-1:0] memwb_rd,
    input  logic            memwb_reg_write,
    input  logic [XLEN-1:0] memwb_result,
    output logic [XLEN-1:0] fwd_data
);

    fwd_sel_e sel;

    always_comb begin
        sel = FWD_NONE;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs_addr)) begin
            sel = FWD_EXMEM;
        end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs_addr)) begin
            sel = FWD_MEMWB;
        end
    end

    always_comb begin
        fwd_data = rs_data;
        case (sel)
            FWD_EXMEM: fwd_data = exmem_result;
            FWD_MEMWB: fwd_data = memwb_result;
            default:   fwd_data = rs_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU, with forwarding, load-use bubbles,
// backpressure and flush. Optional ID_EX_STALL_CNT_EN adds a saturating stall counter.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int RA_W = RA_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave bus
`ifdef ID_EX_STALL_CNT_EN
    ,
    output logic [31:0]  stall_cnt
`endif
);

    logic            valid_reg,       valid_next;
    logic [3:0]      alu_control_reg, alu_control_next;
    logic [RA_W-1:0] rs_addr_reg [2];
    logic [RA_W-1:0] rs_addr_next [2];
    logic [XLEN-1:0] rs_data_reg [2];
    logic [XLEN-1:0] rs_data_next [2];
    logic [XLEN-1:0] imm_reg,         imm_next;
    logic            use_imm_reg,     use_imm_next;
    logic [RA_W-1:0] rd_addr_reg,     rd_addr_next;
    logic            reg_write_reg,   reg_write_next;
    logic            mem_read_reg,    mem_read_next;

    logic [XLEN-1:0] fwd_data [2];
    logic            ex_load;
    logic            load_use;
    logic            slot_free;
    logic            accept;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_mux #(
                .XLEN (XLEN),
                .RA_W (RA_W)
            ) u_fwd_mux (
                .rs_addr         (rs_addr_reg[gi]),
                .rs_data         (rs_data_reg[gi]),
                .exmem_rd        (bus.exmem_rd),
                .exmem_reg_write (bus.exmem_reg_write),
                .exmem_result    (bus.exmem_result),
                .memwb_rd        (bus.memwb_rd),
                .memwb_reg_write (bus.memwb_reg_write),
                .memwb_result    (bus.memwb_result),
                .fwd_data        (fwd_data[gi])
            );
        end
    endgenerate

    // Hazard check is conservative: rs2 counts even when b is the immediate.
    assign ex_load   = valid_reg & mem_read_reg;
    assign load_use  = ex_load && (rd_addr_reg != '0) &&
                       ((rd_addr_reg == bus.id_rs1_addr) || (rd_addr_reg == bus.id_rs2_addr));
    assign slot_free = !valid_reg || bus.ex_ready;
    assign bus.id_ready = slot_free && !load_use;
    assign accept    = bus.id_valid && bus.id_ready;

    always_comb begin
        valid_next       = valid_reg;
        alu_control_next = alu_control_reg;
        rs_addr_next     = rs_addr_reg;
        rs_data_next     = rs_data_reg;
        imm_next         = imm_reg;
        use_imm_next     = use_imm_reg;
        rd_addr_next     = rd_addr_reg;
        reg_write_next   = reg_write_reg;
        mem_read_next    = mem_read_reg;

        if (bus.flush) begin
            valid_next = 1'b0;
        end else if (accept) begin
            valid_next       = 1'b1;
            alu_control_next = bus.id_alu_control;
            rs_addr_next[0]  = bus.id_rs1_addr;
            rs_addr_next[1]  = bus.id_rs2_addr;
            rs_data_next[0]  = bus.id_rs1_data;
            rs_data_next[1]  = bus.id_rs2_data;
            imm_next         = bus.id_imm;
            use_imm_next     = bus.id_use_imm;
            rd_addr_next     = bus.id_rd_addr;
            reg_write_next   = bus.id_reg_write;
            mem_read_next    = bus.id_mem_read;
        end else if (load_use && slot_free) begin
            valid_next = 1'b0;
        end else if (valid_reg && bus.ex_ready) begin
            valid_next = 1'b0;
        end else begin
            // Held: latch forwarded values so results retiring during the stall survive.
            for (int i = 0; i < 2; i++) begin
                rs_data_next[i] = fwd_data[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg       <= 1'b0;
            alu_control_reg <= ALU_ADD;
            for (int i = 0; i < 2; i++) begin
                rs_addr_reg[i] <= '0;
                rs_data_reg[i] <= '0;
            end
            imm_reg         <= '0;
            use_imm_reg     <= 1'b0;
            rd_addr_reg     <= '0;
            reg_write_reg   <= 1'b0;
            mem_read_reg    <= 1'b0;
        end else begin
            valid_reg       <= valid_next;
            alu_control_reg <= alu_control_next;
            rs_addr_reg     <= rs_addr_next;
            rs_data_reg     <= rs_data_next;
            imm_reg         <= imm_next;
            use_imm_reg     <= use_imm_next;
            rd_addr_reg     <= rd_addr_next;
            reg_write_reg   <= reg_write_next;
            mem_read_reg    <= mem_read_next;
        end
    end

    assign bus.ex_valid      = valid_reg;
    assign bus.alu_a         = fwd_data[0];
    assign bus.alu_b         = use_imm_reg ? imm_reg : fwd_data[1];
    assign bus.alu_control   = alu_control_reg;
    assign bus.ex_store_data = fwd_data[1];
    assign bus.ex_rd_addr    = rd_addr_reg;
    assign bus.ex_reg_write  = valid_reg & reg_write_reg;
    assign bus.ex_mem_read   = ex_load;

`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
        end else if (bus.id_valid && !bus.id_ready && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage sitting directly upstream of the ALU; registers decoded operands and control, then drives the ALU's a, b and alu_control inputs.
- Applies EX/MEM and MEM/WB operand forwarding.
- Detects load-use hazards and inserts bubbles.
- Supports valid/ready backpressure from EX and a flush from branch resolution.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register-address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  kill the instruction held in this stage.
- id_valid  in  1  decode presents an instruction.
- id_ready  out  1  stage accepts the instruction this cycle.
- id_alu_control  in  4  ALU opcode.
- id_rs1_addr, id_rs2_addr  in  RA_W  source register addresses.
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_use_imm  in  1  ALU operand b is the immediate.
- id_rd_addr  in  RA_W  destination register.
- id_reg_write  in  1  instruction writes rd.
- id_mem_read  in  1  instruction is a load.
- exmem_rd, memwb_rd  in  RA_W  downstream destination registers.
- exmem_reg_write, memwb_reg_write  in  1  downstream write enables.
- exmem_result, memwb_result  in  XLEN  downstream forwarding data.
- ex_valid  out  1  EX holds a valid instruction.
- ex_ready  in  1  EX/MEM accepts this cycle.
- alu_a, alu_b  out  XLEN  ALU operands.
- alu_control  out  4  ALU opcode.
- ex_store_data  out  XLEN  forwarded rs2 value.
- ex_rd_addr  out  RA_W  registered rd.
- ex_reg_write  out  1  registered write enable.
- ex_mem_read  out  1  registered load flag.

Behaviour:
- Reset (async, rst_n=0):
  - ex_valid=0.
  - All registered fields 0; alu_control=4'b0000 (ADD).
  - Outputs settle to 0 immediately.
- Latency:
  - One cycle from accepted id_valid to ex_valid=1.
  - Full throughput of one instruction per cycle when there is no hazard or stall.
- load_use:
  - Defined as ex_valid & ex_mem_read & ex_rd_addr!=0 & (ex_rd_addr==id_rs1_addr | ex_rd_addr==id_rs2_addr).
  - Checked conservatively on both sources, regardless of id_use_imm.
- Handshake:
  - id_ready = (!ex_valid | ex_ready) & !load_use. Combinational; does not depend on id_valid.
- Register update priority:
  - 1. flush: ex_valid<=0; the ID instruction is not captured, even if id_valid & id_ready.
  - 2. Else if id_valid & id_ready: capture all id_* fields; ex_valid<=1.
  - 3. Else if load_use & (!ex_valid | ex_ready): insert bubble, ex_valid<=0.
  - 4. Else if ex_valid & ex_ready: ex_valid<=0 (drain).
  - 5. Else (held, ex_ready=0): keep all fields. Also refresh the stored rs1/rs2 values with the forwarded values, so forwarding data that leaves the pipeline during the stall is not lost.
- Forwarding (combinational from registered state):
  - Per source: if exmem_reg_write & exmem_rd!=0 & exmem_rd==rs, use exmem_result.
  - Else if memwb_reg_write & memwb_rd!=0 & memwb_rd==rs, use memwb_result.
  - Else use the stored data. EX/MEM has priority over MEM/WB.
- Operand outputs:
  - alu_a = fwd_rs1.
  - alu_b = ex_use_imm ? ex_imm : fwd_rs2.
  - ex_store_data = fwd_rs2, always.
- Bubbles and flushed slots:
  - Fields may hold stale values.
  - ex_reg_write and ex_mem_read must read as 0 whenever ex_valid=0.
- Register x0 is never a forwarding or hazard match.

Optional Feature:
- Macro ID_EX_STALL_CNT_EN.
- When defined:
  - Adds output port stall_cnt, 32 bits.
  - Increments every cycle that id_valid=1 & id_ready=0.
  - Saturates at 32'hFFFFFFFF.
  - Cleared by rst_n only; flush does not clear it.
- When undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Decomposition:
- Package cpu_pkg holds:
  - ALU opcode localparams: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001.
  - XLEN and RA_W defaults.
- One sub-module, fwd_mux:
  - Instantiated twice, once for rs1 and once for rs2.
  - Inputs: register address, stored data, and both downstream rd/we/result triples.
  - Output: the forwarded value.

Test Plan:
- Reset mid-stream: assert rst_n=0 while ex_valid=1 → ex_valid=0, alu_control=0000, alu_a=0 with no clock edge needed.
- ADD accept: id_rs1_data=15, id_rs2_data=25, ctrl 0000, no matches → next cycle ex_valid=1, alu_a=15, alu_b=25.
- Forward priority: stored rs1=7, exmem_rd=memwb_rd=rs1=3 with both writing, exmem_result=40, memwb_result=99 → alu_a=40. Drop exmem_reg_write → alu_a=99. Repeat with rd=0 → alu_a=7.
- Load-use: EX holds a load with rd=5; ID rs2=5, ex_ready=1 → id_ready=0 for one cycle and a bubble is inserted. The next cycle accepts, and memwb forwarding supplies the load data.
- Stall with forward refresh: ex_ready=0 for 3 cycles while exmem forwards 32'hF8000000 to rs1 in the first cycle only → alu_a stays F8000000 through the stall and at release.
- Flush with simultaneous id_valid: flush=1, id_valid=1 → next cycle ex_valid=0 and the instruction is dropped. With ID_EX_STALL_CNT_EN, 4 stalled cycles → stall_cnt=4.
